set_time_ctrl: RTL and testbench
================================

# set_time_ctrl

Button-driven controller that produces the match-length value `max_time` (seconds) rendered by the set-time screen. It sits between the debounced board buttons and the set-time renderer and game timer. While the set-time screen is active, it steps the value up or down with saturation and auto-repeat on hold. It emits a one-cycle commit pulse when the player confirms.

## Interface
- `CLK_HZ`, 100_000_000: system clock rate; documentation only, no logic depends on it.
- `STEP_SEC`, 15: seconds added or removed per step.
- `MIN_SEC`, 30: lower saturation bound.
- `MAX_SEC`, 599: upper saturation bound (9:59, the largest value the single minute digit can show).
- `DEFAULT_SEC`, 60: `max_time` value after reset.
- `HOLD_CYC`, 50_000_000: cycles a button must be held before the first auto-repeat step.
- `RATE_CYC`, 10_000_000: cycles between subsequent auto-repeat steps.

Ports:
- `clk` in 1: system clock. Single clock domain.
- `reset_n` in 1: asynchronous, active-low reset.
- `enable` in 1: high while the set-time screen is shown.
- `btn_up` in 1: level input, already synchronised and debounced.
- `btn_down` in 1: level input, already synchronised and debounced.
- `btn_ok` in 1: level input, already synchronised and debounced.
- `max_time` out 32: current setting in seconds. Always within [MIN_SEC, MAX_SEC].
- `time_valid` out 1: one-cycle pulse when the value is committed.
- `editing` out 1: high in the EDIT state.

## Operation
- Reset values:
  - `max_time` = DEFAULT_SEC.
  - `time_valid` = 0, `editing` = 0.
  - state = IDLE.
  - All edge and repeat registers cleared.
- FSM states are IDLE, EDIT and DONE.
  - IDLE → EDIT on an edge sampling `enable` = 1. Buttons are ignored on that edge.
  - EDIT → DONE on a rising edge of `btn_ok`. `time_valid` = 1 for exactly that next cycle.
  - EDIT → IDLE when `enable` = 0. No pulse is emitted and `max_time` is retained.
  - DONE → IDLE when `enable` = 0.
  - In DONE, all buttons are ignored.
- Rising-edge detection: each button has a previous-sample register that updates every cycle in every state. A button already held when EDIT is entered therefore produces no press.
- A step request occurs:
  - on a press edge, or
  - on an auto-repeat tick of a button that stays continuously held.
- Steps apply only in EDIT, and only when exactly one of `btn_up` and `btn_down` is high.
  - Both buttons high: no step, and both repeat counters are cleared.
- Increment rule: if `max_time` > MAX_SEC − STEP_SEC, the result is MAX_SEC; otherwise `max_time` + STEP_SEC.
- Decrement rule: if `max_time` < MIN_SEC + STEP_SEC, the result is MIN_SEC; otherwise `max_time` − STEP_SEC.
- Arithmetic: comparisons are done against the bounds, so no wrap-around can occur.
- `btn_ok` priority: a `btn_ok` rising edge on the same edge as an up/down request wins. No step is applied, and the commit carries the unmodified value.

## Timing
- Step latency: a press first sampled high at edge k (previous sample 0) updates `max_time` at edge k. The new value is visible during cycle k+1.
- Auto-repeat while held continuously from edge k:
  - repeat steps occur at edges k+HOLD_CYC, k+HOLD_CYC+RATE_CYC, k+HOLD_CYC+2·RATE_CYC, …
  - release, or the other button being pressed, clears the counter.
- The repeat counter width is sized for max(HOLD_CYC, RATE_CYC). The counter saturates and never wraps.
- `time_valid` rises at the edge where the `btn_ok` edge is sampled and falls at the next edge.
- `editing` is registered and tracks the state with no additional delay.
- Reset asserted mid-hold or mid-edit: all outputs return to their reset values immediately, without waiting for a clock edge.

## Structure
- Shared package (`pong_pkg`) holds:
  - the state enum (IDLE, EDIT, DONE);
  - default constants for STEP_SEC, MIN_SEC, MAX_SEC and DEFAULT_SEC, which are shared with the set-time renderer and the game timer.
- One sub-module, `hold_repeat`:
  - inputs: `clk`, `reset_n`, `btn`, `clr`;
  - output: a one-cycle `step` pulse for each press edge and each auto-repeat tick;
  - parameters: HOLD_CYC and RATE_CYC;
  - instantiated twice, once for up and once for down.
- Edge detection for `btn_ok` lives in the top level.

## Test plan
Benches use HOLD_CYC = 4 and RATE_CYC = 2; all other parameters keep their defaults.
- Reset release with buttons idle: `max_time` = 60, `time_valid` = 0, `editing` = 0. Raising `enable` gives `editing` = 1 one cycle later.
- In EDIT, tap `btn_up` once → `max_time` 75. Then tap `btn_down` twice → 60, then 45.
- In EDIT at 570, hold `btn_up` from edge k → 585 at k, 599 at k+4, still 599 at k+6 and k+8 (saturated).
- In EDIT at 45, tap `btn_down` twice → 30, then 30.
- Each of the following leaves `max_time` unchanged:
  - hold `btn_up` and `btn_down` together for 10 cycles;
  - `btn_ok` and `btn_up` rising on the same edge. This case also moves to DONE with one `time_valid` pulse; later `btn_up` taps are ignored until `enable` drops.
- At 90, hold `btn_up` through entry to EDIT → no step. Then drop `enable` → IDLE, `editing` = 0, `max_time` stays 90, no `time_valid`. Then assert `reset_n` = 0 while `btn_down` is held → `max_time` 60 asynchronously.

Source files
------------

// File: rtl/pong_pkg.sv
// Shared definitions for the pong set-time screen, renderer and game timer.
// Holds the set-time FSM state type and the default match-length bounds.
package pong_pkg;

  localparam int unsigned STEP_SEC    = 15;
  localparam int unsigned MIN_SEC     = 30;
  localparam int unsigned MAX_SEC     = 599;
  localparam int unsigned DEFAULT_SEC = 60;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EDIT = 2'd1,
    DONE = 2'd2
  } set_state_t;

endpackage

// File: rtl/hold_repeat.sv
// Press-edge and auto-repeat step generator for one debounced button.
// step is combinational so a press changes the setting on the edge where it is first sampled.
module hold_repeat #(
  parameter int unsigned HOLD_CYC = 50_000_000,
  parameter int unsigned RATE_CYC = 10_000_000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic btn,
  input  logic clr,
  output logic step
);

  localparam int unsigned CNT_MAX = (HOLD_CYC > RATE_CYC) ? HOLD_CYC : RATE_CYC;
  localparam int unsigned CW      = $clog2(CNT_MAX + 1);

  logic          prev;
  logic          first;
  logic [CW-1:0] cnt;
  logic          press;
  logic          tick;

  // cnt == 0 means not armed: a button held without a seen press edge never repeats.
  always_comb begin
    press = btn & ~prev;
    tick  = btn & (cnt != '0) & (first ? (cnt == CW'(HOLD_CYC)) : (cnt == CW'(RATE_CYC)));
    step  = ~clr & (press | tick);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prev  <= 1'b0;
      first <= 1'b1;
      cnt   <= '0;
    end else begin
      prev <= btn;
      if (clr || !btn) begin
        first <= 1'b1;
        cnt   <= '0;
      end else if (press) begin
        first <= 1'b1;
        cnt   <= CW'(1);
      end else if (tick) begin
        first <= 1'b0;
        cnt   <= CW'(1);
      end else if (cnt != '0 && cnt != '1) begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/set_time_ctrl.sv
// Set-time screen controller: steps max_time with saturation and auto-repeat,
// and emits a one-cycle time_valid pulse when the player confirms with btn_ok.
module set_time_ctrl
  import pong_pkg::*;
#(
  parameter int unsigned CLK_HZ      = 100_000_000,
  parameter int unsigned STEP_SEC    = pong_pkg::STEP_SEC,
  parameter int unsigned MIN_SEC     = pong_pkg::MIN_SEC,
  parameter int unsigned MAX_SEC     = pong_pkg::MAX_SEC,
  parameter int unsigned DEFAULT_SEC = pong_pkg::DEFAULT_SEC,
  parameter int unsigned HOLD_CYC    = 50_000_000,
  parameter int unsigned RATE_CYC    = 10_000_000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        enable,
  input  logic        btn_up,
  input  logic        btn_down,
  input  logic        btn_ok,
  output logic [31:0] max_time,
  output logic        time_valid,
  output logic        editing
);

  if (CLK_HZ == 0 || MIN_SEC > DEFAULT_SEC || DEFAULT_SEC > MAX_SEC) begin : g_bad_params
    $error("set_time_ctrl: inconsistent parameters");
  end

  set_state_t  state;
  logic        ok_prev;
  logic        ok_edge;
  logic        both;
  logic        clr;
  logic        up_step;
  logic        down_step;
  logic [31:0] inc_val;
  logic [31:0] dec_val;

  always_comb begin
    ok_edge = btn_ok & ~ok_prev;
    both    = btn_up & btn_down;
    clr     = (state != EDIT) | both;
    inc_val = (max_time > 32'(MAX_SEC - STEP_SEC)) ? 32'(MAX_SEC) : max_time + 32'(STEP_SEC);
    dec_val = (max_time < 32'(MIN_SEC + STEP_SEC)) ? 32'(MIN_SEC) : max_time - 32'(STEP_SEC);
  end

  hold_repeat #(.HOLD_CYC(HOLD_CYC), .RATE_CYC(RATE_CYC)) u_up (
    .clk     (clk),
    .reset_n (reset_n),
    .btn     (btn_up),
    .clr     (clr),
    .step    (up_step)
  );

  hold_repeat #(.HOLD_CYC(HOLD_CYC), .RATE_CYC(RATE_CYC)) u_down (
    .clk     (clk),
    .reset_n (reset_n),
    .btn     (btn_down),
    .clr     (clr),
    .step    (down_step)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      ok_prev    <= 1'b0;
      max_time   <= 32'(DEFAULT_SEC);
      time_valid <= 1'b0;
      editing    <= 1'b0;
    end else begin
      ok_prev    <= btn_ok;
      time_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (enable) begin
            state   <= EDIT;
            editing <= 1'b1;
          end
        end
        EDIT: begin
          if (!enable) begin
            state   <= IDLE;
            editing <= 1'b0;
          end else if (ok_edge) begin
            state      <= DONE;
            editing    <= 1'b0;
            time_valid <= 1'b1;
          end else if (up_step) begin
            max_time <= inc_val;
          end else if (down_step) begin
            max_time <= dec_val;
          end
        end
        DONE: begin
          if (!enable) state <= IDLE;
        end
        default: begin
          state   <= IDLE;
          editing <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_set_time_ctrl.sv
// Directed bench for set_time_ctrl with short hold/repeat timing (HOLD_CYC=4, RATE_CYC=2).
module tb_set_time_ctrl;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        enable;
  logic        btn_up;
  logic        btn_down;
  logic        btn_ok;
  logic [31:0] max_time;
  logic        time_valid;
  logic        editing;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  always #5 clk = ~clk;

  set_time_ctrl #(.HOLD_CYC(4), .RATE_CYC(2)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .enable     (enable),
    .btn_up     (btn_up),
    .btn_down   (btn_down),
    .btn_ok     (btn_ok),
    .max_time   (max_time),
    .time_valid (time_valid),
    .editing    (editing)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
  endtask

  task automatic tick(input int unsigned n = 1);
    for (int unsigned i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic tap_up();
    btn_up = 1'b1; tick();
    btn_up = 1'b0; tick();
  endtask

  task automatic tap_down();
    btn_down = 1'b1; tick();
    btn_down = 1'b0; tick();
  endtask

  initial begin
    reset_n = 1'b0; enable = 1'b0;
    btn_up = 1'b0; btn_down = 1'b0; btn_ok = 1'b0;
    #12 reset_n = 1'b1;
    check("rst_max", max_time, 60);
    check("rst_valid", {31'd0, time_valid}, 0);
    check("rst_edit", {31'd0, editing}, 0);

    enable = 1'b1; tick();
    check("enter_edit", {31'd0, editing}, 1);

    btn_up = 1'b1; tick();
    check("tap_up", max_time, 75);
    btn_up = 1'b0; tick();
    btn_down = 1'b1; tick();
    check("tap_down1", max_time, 60);
    btn_down = 1'b0; tick();
    btn_down = 1'b1; tick();
    check("tap_down2", max_time, 45);
    btn_down = 1'b0; tick();

    for (int unsigned i = 0; i < 35; i++) tap_up();
    check("reach_570", max_time, 570);

    btn_up = 1'b1; tick();
    check("hold_k", max_time, 585);
    tick(3);
    check("hold_k3", max_time, 585);
    tick();
    check("hold_k4", max_time, 599);
    tick(2);
    check("hold_k6", max_time, 599);
    tick(2);
    check("hold_k8", max_time, 599);
    btn_up = 1'b0; tick();

    // Reset back to default, then re-enter EDIT to walk down to the floor.
    reset_n = 1'b0; #2;
    check("reset_mid_edit", max_time, 60);
    reset_n = 1'b1; tick();
    check("reenter_edit", {31'd0, editing}, 1);
    tap_down();
    check("down_45", max_time, 45);
    tap_down();
    check("down_30", max_time, 30);
    tap_down();
    check("down_sat", max_time, 30);

    tap_up();
    check("up_45", max_time, 45);
    btn_up = 1'b1; btn_down = 1'b1; tick(10);
    check("both_held", max_time, 45);
    btn_up = 1'b0; btn_down = 1'b0; tick();
    check("both_release", max_time, 45);

    btn_ok = 1'b1; btn_up = 1'b1; tick();
    check("ok_wins_max", max_time, 45);
    check("ok_pulse", {31'd0, time_valid}, 1);
    check("done_edit", {31'd0, editing}, 0);
    tick();
    check("ok_pulse_end", {31'd0, time_valid}, 0);
    btn_ok = 1'b0; btn_up = 1'b0; tick();
    tap_up();
    check("done_ignore_up", max_time, 45);
    check("done_no_pulse", {31'd0, time_valid}, 0);

    enable = 1'b0; tick();
    enable = 1'b1; tick();
    for (int unsigned i = 0; i < 3; i++) tap_up();
    check("reach_90", max_time, 90);
    enable = 1'b0; tick();
    btn_up = 1'b1; enable = 1'b1; tick();
    check("held_entry_edit", {31'd0, editing}, 1);
    check("held_entry_max", max_time, 90);
    tick(6);
    check("held_no_repeat", max_time, 90);
    enable = 1'b0; tick();
    check("drop_edit", {31'd0, editing}, 0);
    check("drop_max", max_time, 90);
    check("drop_valid", {31'd0, time_valid}, 0);
    btn_up = 1'b0; btn_down = 1'b1; tick();
    reset_n = 1'b0; #1;
    check("async_rst_max", max_time, 60);
    check("async_rst_edit", {31'd0, editing}, 0);
    btn_down = 1'b0;
    tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
